mul_selftest: RTL and testbench

Parametrised built-in self-test engine for the W×W multipliers in this codebase. It drives pseudo-random operand pairs and a signed/unsigned mode into an external multiplier DUT, and computes the reference product itself. It compares the DUT result after a configurable pipeline latency, counts mismatches and captures the first failing vector. It replaces ad-hoc board-level checking and supports pipelined multipliers, arbitrary width and a bounded vector count.

---
 rtl/mul_selftest_pkg.sv | 24 ++
 rtl/mul_selftest_lfsr.sv | 26 ++
 rtl/mul_selftest.sv | 227 ++++++++++++++++++++++
 tb/tb_mul_selftest.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_selftest_pkg.sv
// Shared types and constants for the multiplier self-test engine.
package mul_selftest_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Values of the MODE_SEL parameter
  localparam int MODE_SEL_UNSIGNED  = 0;
  localparam int MODE_SEL_SIGNED    = 1;
  localparam int MODE_SEL_ALTERNATE = 2;

  // Values driven on op_mode
  localparam logic OP_UNSIGNED = 1'b0;
  localparam logic OP_SIGNED   = 1'b1;

  // Default Galois tap masks for the two operand generators
  localparam logic [31:0] MASK_A_DEFAULT = 32'h8020_0003;
  localparam logic [31:0] MASK_B_DEFAULT = 32'h8000_0063;

endpackage

// File: rtl/mul_selftest_lfsr.sv
// Galois LFSR operand generator. A zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module lfsr_galois #(
  parameter int           W    = 32,
  parameter logic [W-1:0] MASK = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         step,
  output logic [W-1:0] q
);

  // Load the seed on request, otherwise advance one Galois step when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= (seed == '0) ? W'(1) : seed;
    end else if (step) begin
      q <= (q >> 1) ^ (q[0] ? MASK : '0);
    end
  end

endmodule

// File: rtl/mul_selftest.sv
// Built-in self-test engine for an external WxW multiplier. Issues one
// pseudo-random vector per cycle, computes the reference product itself,
// compares the DUT result LAT cycles later and records the first failure.
module mul_selftest
  import mul_selftest_pkg::*;
#(
  parameter int           W        = 32,
  parameter int           NUM_VEC  = 1024,
  parameter int           LAT      = 0,
  parameter int           MODE_SEL = 2,
  parameter logic [W-1:0] MASK_A   = W'(MASK_A_DEFAULT),
  parameter logic [W-1:0] MASK_B   = W'(MASK_B_DEFAULT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [W-1:0]                   seed_a,
  input  logic [W-1:0]                   seed_b,
  output logic [W-1:0]                   op_a,
  output logic [W-1:0]                   op_b,
  output logic                           op_mode,
  input  logic [2*W-1:0]                 res,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [15:0]                    err_count,
  output logic [W-1:0]                   fail_a,
  output logic [W-1:0]                   fail_b,
  output logic                           fail_mode,
  output logic [2*W-1:0]                 fail_got,
  output logic [2*W-1:0]                 fail_exp,
  output logic [$clog2(NUM_VEC+1)-1:0]   fail_idx
);

  localparam int IDXW = $clog2(NUM_VEC + 1);
  localparam int DCW  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int PW   = 2 * W;
  localparam int DW   = PW + W + W + 1 + IDXW;

  state_t          state;
  state_t          state_next;
  logic [IDXW-1:0] vec_idx;
  logic [DCW-1:0]  drain_cnt;
  logic            accept;
  logic            last_vec;
  logic            drain_last;
  logic            issue_step;

  logic [PW-1:0]   exp_u;
  logic [PW-1:0]   exp_s;
  logic [PW-1:0]   exp_cur;
  logic [DW-1:0]   entry;
  logic            entry_valid;
  logic [DW-1:0]   cmp_entry;
  logic            cmp_valid;
  logic [IDXW-1:0] cmp_idx;
  logic            cmp_mode;
  logic [W-1:0]    cmp_a;
  logic [W-1:0]    cmp_b;
  logic [PW-1:0]   cmp_exp;
  logic            mismatch;

  // A start only counts when the engine is not already running
  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign last_vec   = (vec_idx == IDXW'(NUM_VEC - 1));
  assign drain_last = (LAT == 0) || (drain_cnt == DCW'(LAT - 1));
  // The last vector is held on op_* so DONE shows the final operands
  assign issue_step = (state == RUN) && !last_vec;

  lfsr_galois #(.W(W), .MASK(MASK_A)) u_lfsr_a (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .seed (seed_a),
    .step (issue_step),
    .q    (op_a)
  );

  lfsr_galois #(.W(W), .MASK(MASK_B)) u_lfsr_b (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .seed (seed_b),
    .step (issue_step),
    .q    (op_b)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_vec) state_next = (LAT == 0) ? DONE : DRAIN;
      DRAIN:   if (drain_last) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // FSM status outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    if ((state == RUN) || (state == DRAIN)) busy = 1'b1;
    if (state == DONE) begin
      done = 1'b1;
      pass = (err_count == 16'd0);
    end
  end

  // Vector index and drain counter
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_idx   <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        vec_idx <= '0;
      end else if (issue_step) begin
        vec_idx <= vec_idx + IDXW'(1);
      end
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + DCW'(1);
      end else begin
        drain_cnt <= '0;
      end
    end
  end

  // Operand mode: fixed, or toggling per vector starting unsigned
  always_ff @(posedge clk) begin
    if (rst) begin
      op_mode <= OP_UNSIGNED;
    end else if (accept) begin
      op_mode <= (MODE_SEL == MODE_SEL_SIGNED) ? OP_SIGNED : OP_UNSIGNED;
    end else if (issue_step && (MODE_SEL == MODE_SEL_ALTERNATE)) begin
      op_mode <= ~op_mode;
    end
  end

  // Reference product: truncating the product of sign-extended operands to
  // 2W bits gives the two's-complement signed product
  always_comb begin
    exp_u   = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
    exp_s   = {{W{op_a[W-1]}}, op_a} * {{W{op_b[W-1]}}, op_b};
    exp_cur = op_mode ? exp_s : exp_u;
  end

  assign entry       = {exp_cur, op_a, op_b, op_mode, vec_idx};
  assign entry_valid = (state == RUN);

  generate
    if (LAT == 0) begin : g_nodelay
      assign cmp_entry = entry;
      assign cmp_valid = entry_valid;
    end else begin : g_delay
      logic [DW-1:0]  dl_data [LAT];
      logic [LAT-1:0] dl_valid;

      // Valid tags, flushed by reset so no stale vector is compared
      always_ff @(posedge clk) begin
        if (rst) begin
          dl_valid <= '0;
        end else begin
          dl_valid[0] <= entry_valid;
          for (int i = 1; i < LAT; i++) begin
            dl_valid[i] <= dl_valid[i-1];
          end
        end
      end

      // Payload shift register, qualified only by the valid tags
      always_ff @(posedge clk) begin
        dl_data[0] <= entry;
        for (int i = 1; i < LAT; i++) begin
          dl_data[i] <= dl_data[i-1];
        end
      end

      assign cmp_entry = dl_data[LAT-1];
      assign cmp_valid = dl_valid[LAT-1];
    end
  endgenerate

  assign cmp_idx  = cmp_entry[IDXW-1:0];
  assign cmp_mode = cmp_entry[IDXW];
  assign cmp_b    = cmp_entry[IDXW+1 +: W];
  assign cmp_a    = cmp_entry[IDXW+1+W +: W];
  assign cmp_exp  = cmp_entry[IDXW+1+2*W +: PW];
  assign mismatch = cmp_valid && (res != cmp_exp);

  // Error counting and first-failure capture
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_mode <= 1'b0;
      fail_got  <= '0;
      fail_exp  <= '0;
      fail_idx  <= '0;
    end else if (mismatch) begin
      if (err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
      if (err_count == 16'd0) begin
        fail_a    <= cmp_a;
        fail_b    <= cmp_b;
        fail_mode <= cmp_mode;
        fail_got  <= res;
        fail_exp  <= cmp_exp;
        fail_idx  <= cmp_idx;
      end
    end
  end

endmodule

// File: tb/tb_mul_selftest.sv
// Directed bench for mul_selftest: an 8-bit, LAT=2 engine driving a
// behavioural multiplier with selectable faults, and a 32-bit LAT=0 engine
// driving a golden combinational multiplier.
module tb_mul_selftest;

  logic clk;
  logic rst;

  // 8-bit engine
  logic        start8;
  logic [7:0]  seed_a8, seed_b8;
  logic [7:0]  op_a8, op_b8;
  logic        op_mode8;
  logic [15:0] res8;
  logic        busy8, done8, pass8;
  logic [15:0] err8;
  logic [7:0]  fail_a8, fail_b8;
  logic        fail_mode8;
  logic [15:0] fail_got8, fail_exp8;
  logic [3:0]  fail_idx8;

  // 32-bit engine
  logic        start32;
  logic [31:0] seed_a32, seed_b32;
  logic [31:0] op_a32, op_b32;
  logic        op_mode32;
  logic [63:0] res32;
  logic        busy32, done32, pass32;
  logic [15:0] err32;
  logic [31:0] fail_a32, fail_b32;
  logic        fail_mode32;
  logic [63:0] fail_got32, fail_exp32;
  logic [4:0]  fail_idx32;

  int fault8;
  int checks;
  int errors;

  logic [15:0] p8;
  logic [15:0] pipe1, pipe2;

  mul_selftest #(
    .W(8), .NUM_VEC(8), .LAT(2), .MODE_SEL(2),
    .MASK_A(8'hB8), .MASK_B(8'h8E)
  ) u_dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .seed_a(seed_a8), .seed_b(seed_b8),
    .op_a(op_a8), .op_b(op_b8), .op_mode(op_mode8),
    .res(res8),
    .busy(busy8), .done(done8), .pass(pass8),
    .err_count(err8),
    .fail_a(fail_a8), .fail_b(fail_b8), .fail_mode(fail_mode8),
    .fail_got(fail_got8), .fail_exp(fail_exp8), .fail_idx(fail_idx8)
  );

  mul_selftest #(
    .W(32), .NUM_VEC(16), .LAT(0), .MODE_SEL(2)
  ) u_dut32 (
    .clk(clk), .rst(rst), .start(start32),
    .seed_a(seed_a32), .seed_b(seed_b32),
    .op_a(op_a32), .op_b(op_b32), .op_mode(op_mode32),
    .res(res32),
    .busy(busy32), .done(done32), .pass(pass32),
    .err_count(err32),
    .fail_a(fail_a32), .fail_b(fail_b32), .fail_mode(fail_mode32),
    .fail_got(fail_got32), .fail_exp(fail_exp32), .fail_idx(fail_idx32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] prod8(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic signed [15:0] s;
    if (m) begin
      s = $signed(a) * $signed(b);
      return s;
    end
    return 16'(a) * 16'(b);
  endfunction

  function automatic logic [63:0] prod32(input logic [31:0] a, input logic [31:0] b, input logic m);
    logic signed [63:0] s;
    if (m) begin
      s = $signed(a) * $signed(b);
      return s;
    end
    return 64'(a) * 64'(b);
  endfunction

  // Faulty multiplier: 0 golden, 1 clears bit 0 of signed results,
  // 2 always returns the unsigned product
  always_comb begin
    p8 = prod8(op_a8, op_b8, op_mode8);
    if (fault8 == 1 && op_mode8) p8[0] = 1'b0;
    if (fault8 == 2) p8 = 16'(op_a8) * 16'(op_b8);
  end

  // Two-stage pipeline to match LAT=2
  always @(posedge clk) begin
    pipe1 <= p8;
    pipe2 <= pipe1;
  end
  assign res8 = pipe2;

  assign res32 = prod32(op_a32, op_b32, op_mode32);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start8(input logic [7:0] a, input logic [7:0] b);
    seed_a8 = a;
    seed_b8 = b;
    start8  = 1'b1;
    tick();
    start8  = 1'b0;
  endtask

  task automatic wait_done8(output int lat, output int busy_cyc);
    lat = 1;
    busy_cyc = 0;
    while (!done8 && lat < 200) begin
      if (busy8) busy_cyc++;
      tick();
      lat++;
    end
  endtask

  // Expected mismatch count and first failing index for an 8-vector run
  task automatic model8(input logic [7:0] sa, input logic [7:0] sb, input int fault,
                        output int nerr, output int first);
    logic [7:0]  a, b;
    logic        m;
    logic [15:0] good, got;
    a = (sa == 8'h00) ? 8'h01 : sa;
    b = (sb == 8'h00) ? 8'h01 : sb;
    nerr = 0;
    first = -1;
    for (int k = 0; k < 8; k++) begin
      m = ((k % 2) == 1);
      good = prod8(a, b, m);
      got = good;
      if (fault == 1 && m) got[0] = 1'b0;
      if (fault == 2) got = 16'(a) * 16'(b);
      if (got != good) begin
        if (first < 0) first = k;
        nerr++;
      end
      a = (a >> 1) ^ (a[0] ? 8'hB8 : 8'h00);
      b = (b >> 1) ^ (b[0] ? 8'h8E : 8'h00);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({op_a8, op_b8, op_mode8, busy8, done8, pass8} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL reset_ops8: got %h expected 0", {op_a8, op_b8, op_mode8, busy8, done8, pass8});
    end
    checks++;
    if ({err8, fail_a8, fail_b8, fail_mode8, fail_got8, fail_exp8, fail_idx8} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_fail8: err %h idx %h exp %h expected all 0", err8, fail_idx8, fail_exp8);
    end
    checks++;
    if ({op_a32, busy32, done32, pass32, err32, fail_exp32} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_32: op_a %h err %h expected 0", op_a32, err32);
    end
  endtask

  task automatic test_lfsr_sequence();
    logic [7:0] exp_a [8] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8};
    logic [7:0] exp_b [8] = '{8'h01, 8'h8E, 8'h47, 8'hAD, 8'hD8, 8'h6C, 8'h36, 8'h1B};
    int lat, bc;
    fault8 = 0;
    pulse_start8(8'h00, 8'h01);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({op_a8, op_b8, op_mode8, busy8} !== {exp_a[k], exp_b[k], (k % 2) == 1, 1'b1}) begin
        errors++;
        $display("[TB] FAIL vec8_%0d: got a=%h b=%h m=%b busy=%b expected a=%h b=%h m=%0d busy=1",
                 k, op_a8, op_b8, op_mode8, busy8, exp_a[k], exp_b[k], k % 2);
      end
      tick();
    end
    wait_done8(lat, bc);
    tick();
    tick();
    checks++;
    if ({done8, pass8, op_a8, op_b8, op_mode8} !== {1'b1, 1'b1, 8'hC8, 8'h1B, 1'b1}) begin
      errors++;
      $display("[TB] FAIL done_hold8: got done=%b pass=%b a=%h b=%h m=%b expected 1 1 c8 1b 1",
               done8, pass8, op_a8, op_b8, op_mode8);
    end
  endtask

  task automatic test_golden8();
    int lat, bc;
    fault8 = 0;
    pulse_start8(8'h5A, 8'hC3);
    wait_done8(lat, bc);
    checks++;
    if (lat != 11 || bc != 10) begin
      errors++;
      $display("[TB] FAIL golden8_timing: got lat=%0d busy=%0d expected lat=11 busy=10", lat, bc);
    end
    checks++;
    if (pass8 !== 1'b1 || err8 !== 16'd0) begin
      errors++;
      $display("[TB] FAIL golden8_pass: got pass=%b err=%0d expected pass=1 err=0", pass8, err8);
    end
  endtask

  task automatic test_signed_lsb_fault();
    int lat, bc, nerr, first;
    fault8 = 1;
    model8(8'h8F, 8'h02, 1, nerr, first);
    pulse_start8(8'h8F, 8'h02);
    wait_done8(lat, bc);
    checks++;
    if (err8 !== 16'(nerr) || pass8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lsb_count: got err=%0d pass=%b expected err=%0d pass=0", err8, pass8, nerr);
    end
    checks++;
    if (fail_idx8 !== 4'd1 || first != 1 || fail_mode8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lsb_idx: got idx=%0d mode=%b expected idx=1 mode=1", fail_idx8, fail_mode8);
    end
    checks++;
    if ({fail_a8, fail_b8, fail_exp8, fail_got8} !== {8'hFF, 8'h01, 16'hFFFF, 16'hFFFE}) begin
      errors++;
      $display("[TB] FAIL lsb_vector: got a=%h b=%h exp=%h got=%h expected ff 01 ffff fffe",
               fail_a8, fail_b8, fail_exp8, fail_got8);
    end
  endtask

  task automatic test_unsigned_both();
    int lat, bc, nerr, first;
    fault8 = 2;
    model8(8'h8F, 8'hE3, 2, nerr, first);
    pulse_start8(8'h8F, 8'hE3);
    wait_done8(lat, bc);
    checks++;
    if (err8 !== 16'(nerr) || err8 == 16'd0) begin
      errors++;
      $display("[TB] FAIL uns_count: got err=%0d expected %0d", err8, nerr);
    end
    checks++;
    if ({fail_idx8, fail_mode8, fail_a8, fail_b8, fail_exp8, fail_got8} !==
        {4'd1, 1'b1, 8'hFF, 8'hFF, 16'h0001, 16'hFE01}) begin
      errors++;
      $display("[TB] FAIL uns_vector: got idx=%0d mode=%b a=%h b=%h exp=%h got=%h expected 1 1 ff ff 0001 fe01",
               fail_idx8, fail_mode8, fail_a8, fail_b8, fail_exp8, fail_got8);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    fault8 = 0;
    pulse_start8(8'h33, 8'h99);
    checks++;
    if (err8 !== 16'd0 || fail_idx8 !== 4'd0 || fail_exp8 !== 16'd0 || busy8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_clear: got err=%0d idx=%0d exp=%h busy=%b expected 0 0 0 1",
               err8, fail_idx8, fail_exp8, busy8);
    end
    wait_done8(lat, bc);
    checks++;
    if (lat != 11 || pass8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_pass: got lat=%0d pass=%b expected 11 1", lat, pass8);
    end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] exp_a [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    int lat, bc;
    fault8 = 0;
    pulse_start8(8'h01, 8'h01);
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (op_a8 !== 8'hB3) begin
      errors++;
      $display("[TB] FAIL midrun_vec5: got %h expected b3", op_a8);
    end
    fault8 = 2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({op_a8, op_b8, op_mode8, busy8, done8, pass8, err8, fail_idx8} !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got a=%h b=%h busy=%b done=%b err=%0d expected all 0",
               op_a8, op_b8, busy8, done8, err8);
    end
    tick();
    tick();
    checks++;
    if (err8 !== 16'd0 || busy8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun_flush: got err=%0d busy=%b expected 0 0", err8, busy8);
    end
    fault8 = 0;
    pulse_start8(8'h01, 8'h01);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (op_a8 !== exp_a[k] || op_mode8 !== ((k % 2) == 1)) begin
        errors++;
        $display("[TB] FAIL restart_vec%0d: got a=%h m=%b expected a=%h m=%0d", k, op_a8, op_mode8, exp_a[k], k % 2);
      end
      tick();
    end
    wait_done8(lat, bc);
    checks++;
    if (done8 !== 1'b1 || pass8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_done: got done=%b pass=%b expected 1 1", done8, pass8);
    end
  endtask

  task automatic test_lat0_32();
    int lat, bc;
    seed_a32 = 32'h1;
    seed_b32 = 32'h1;
    start32  = 1'b1;
    tick();
    start32  = 1'b0;
    checks++;
    if ({op_a32, op_b32, op_mode32} !== {32'h1, 32'h1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL w32_vec0: got a=%h b=%h m=%b expected 1 1 0", op_a32, op_b32, op_mode32);
    end
    lat = 1;
    bc = 1;
    tick();
    lat++;
    checks++;
    if ({op_a32, op_b32, op_mode32} !== {32'h8020_0003, 32'h8000_0063, 1'b1}) begin
      errors++;
      $display("[TB] FAIL w32_step: got a=%h b=%h m=%b expected 80200003 80000063 1", op_a32, op_b32, op_mode32);
    end
    while (!done32 && lat < 200) begin
      if (busy32) bc++;
      tick();
      lat++;
    end
    checks++;
    if (lat != 17 || bc != 16) begin
      errors++;
      $display("[TB] FAIL w32_timing: got lat=%0d busy=%0d expected lat=17 busy=16", lat, bc);
    end
    checks++;
    if (pass32 !== 1'b1 || err32 !== 16'd0) begin
      errors++;
      $display("[TB] FAIL w32_pass: got pass=%b err=%0d expected 1 0", pass32, err32);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    fault8   = 0;
    rst      = 1'b1;
    start8   = 1'b0;
    start32  = 1'b0;
    seed_a8  = '0;
    seed_b8  = '0;
    seed_a32 = '0;
    seed_b32 = '0;
    test_reset();
    test_lfsr_sequence();
    test_golden8();
    test_signed_lsb_fault();
    test_unsigned_both();
    test_back_to_back();
    test_reset_midrun();
    test_lat0_32();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
